// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous memory between two masters: port 0 (the
// cpu) and port 1 (a debug/loader unit). Each cycle at most one requester is
// granted. Ownership alternates round-robin when both ports compete. A master
// may hold the bus across several grants with its lock input. The lock is
// forcibly broken after MAX_LOCK consecutive locked grants if the other port
// is waiting. Read data returns one cycle after the grant, tagged to the port
// that issued the read.
//
// Parameters
//   ADDR_WIDTH  memory address width
//   DATA_WIDTH  memory word width
//   MAX_LOCK    consecutive locked grants allowed before a forced release
//               while the other port waits (1..255)
//
// Ports
//   clk                    rising-edge clock
//   rst_n                  asynchronous active-low reset
//   i_mN_req               access request, held by the master until granted
//   i_mN_lock              keep ownership after the current grant
//   i_mN_we                1 = write, 0 = read
//   i_mN_addr, i_mN_data   access address and write data
//   o_mN_gnt               request accepted this cycle (combinational)
//   o_mN_rvalid            read data for port N is valid this cycle
//   o_mN_rdata             read data, zero whenever o_mN_rvalid is low
//   o_mem_we/addr/data     memory command, all zero on idle cycles
//   i_mem_in               memory read output, valid the cycle after a read
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_LOCK   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // port 0 (cpu)
   input  logic                  i_m0_req,
   input  logic                  i_m0_lock,
   input  logic                  i_m0_we,
   input  logic [ADDR_WIDTH-1:0] i_m0_addr,
   input  logic [DATA_WIDTH-1:0] i_m0_data,
   output logic                  o_m0_gnt,
   output logic                  o_m0_rvalid,
   output logic [DATA_WIDTH-1:0] o_m0_rdata,
   // port 1 (debug / loader)
   input  logic                  i_m1_req,
   input  logic                  i_m1_lock,
   input  logic                  i_m1_we,
   input  logic [ADDR_WIDTH-1:0] i_m1_addr,
   input  logic [DATA_WIDTH-1:0] i_m1_data,
   output logic                  o_m1_gnt,
   output logic                  o_m1_rvalid,
   output logic [DATA_WIDTH-1:0] o_m1_rdata,
   // memory side
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_data,
   input  logic [DATA_WIDTH-1:0] i_mem_in
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } state_e;

   localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e     r_state;
   logic       r_last;       // port that received the most recent grant
   logic [7:0] r_lock_cnt;   // grants given under the current lock
   logic       r_rpend;      // a read was granted last cycle
   logic       r_rsel;       // port that owns the pending read

   state_e     w_state_nxt;
   logic       w_last_nxt;
   logic [7:0] w_lock_cnt_nxt;
   logic       w_rpend_nxt;
   logic       w_rsel_nxt;

   // ---------------------------------------------------------------------------
   // Per-port views, indexable by port number
   // ---------------------------------------------------------------------------
   logic [1:0]            w_req;
   logic [1:0]            w_lock;
   logic [1:0]            w_we;
   logic [ADDR_WIDTH-1:0] w_addr [2];
   logic [DATA_WIDTH-1:0] w_data [2];

   assign w_req     = {i_m1_req,  i_m0_req};
   assign w_lock    = {i_m1_lock, i_m0_lock};
   assign w_we      = {i_m1_we,   i_m0_we};
   assign w_addr[0] = i_m0_addr;
   assign w_addr[1] = i_m1_addr;
   assign w_data[0] = i_m0_data;
   assign w_data[1] = i_m1_data;

   // ---------------------------------------------------------------------------
   // Grant decision signals (driven by the output process)
   // ---------------------------------------------------------------------------
   logic w_locked;      // bus is currently held by a lock
   logic w_owner;       // lock holder (meaningful only when w_locked)
   logic w_other;       // the port that is not the lock holder
   logic w_free;        // arbitrate round-robin this cycle
   logic w_force_rel;   // lock budget exhausted while the other port waits
   logic w_gnt_any;     // a grant is issued this cycle
   logic w_gnt_port;    // which port is granted (meaningful with w_gnt_any)

   // ---------------------------------------------------------------------------
   // Process 1: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values computed before the edge, independent of statement
   // order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_last     <= 1'b1;       // port 0 wins the first tie after reset
         r_lock_cnt <= 8'd0;
         r_rpend    <= 1'b0;       // any read in flight is discarded
         r_rsel     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_last     <= w_last_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_rpend    <= w_rpend_nxt;
         r_rsel     <= w_rsel_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Process 2: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal written in a combinational block gets a default at the
   // top, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt    = r_state;
      w_last_nxt     = r_last;
      w_lock_cnt_nxt = r_lock_cnt;
      w_rpend_nxt    = w_gnt_any && !w_we[w_gnt_port];
      w_rsel_nxt     = w_gnt_any ? w_gnt_port : r_rsel;

      if (w_force_rel) begin
         // Hand the bus back; last stays on the holder so the waiting port
         // wins the round-robin tie on the next cycle.
         w_state_nxt = ST_IDLE;
         w_last_nxt  = w_owner;
      end else if (w_gnt_any) begin
         w_last_nxt = w_gnt_port;
         if (w_free) begin
            // Fresh grant: a lock here starts a new locked sequence.
            if (w_lock[w_gnt_port]) begin
               w_state_nxt    = w_gnt_port ? ST_LOCK1 : ST_LOCK0;
               w_lock_cnt_nxt = 8'd1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end else begin
            // Grant inside a locked sequence; the counter saturates.
            if (r_lock_cnt != 8'hFF) begin
               w_lock_cnt_nxt = r_lock_cnt + 8'd1;
            end
            if (!w_lock[w_owner]) begin
               w_state_nxt = ST_IDLE;
            end
         end
      end else if (w_free) begin
         // No grant and no live lock: settle in IDLE.
         w_state_nxt = ST_IDLE;
      end
   end

   // ---------------------------------------------------------------------------
   // Process 3: outputs (grant selection and memory command)
   // ---------------------------------------------------------------------------
   always_comb begin
      w_locked    = (r_state != ST_IDLE);
      w_owner     = (r_state == ST_LOCK1);
      w_other     = ~w_owner;

      // A holder that neither requests nor keeps its lock has released the
      // bus already, so this cycle is arbitrated as if IDLE and the other
      // port can be served without a dead cycle.
      w_free      = !w_locked || (!w_req[w_owner] && !w_lock[w_owner]);

      // Budget spent and the other port is waiting: the holder gets nothing
      // this cycle and the FSM drops to IDLE.
      w_force_rel = !w_free && (r_lock_cnt >= MAX_LOCK_C) && w_req[w_other];

      w_gnt_any  = 1'b0;
      w_gnt_port = 1'b0;
      if (w_free) begin
         if (w_req[0] && w_req[1]) begin
            w_gnt_any  = 1'b1;
            w_gnt_port = ~r_last;
         end else if (w_req[0]) begin
            w_gnt_any  = 1'b1;
            w_gnt_port = 1'b0;
         end else if (w_req[1]) begin
            w_gnt_any  = 1'b1;
            w_gnt_port = 1'b1;
         end
      end else if (!w_force_rel && w_req[w_owner]) begin
         w_gnt_any  = 1'b1;
         w_gnt_port = w_owner;
      end

      o_m0_gnt = w_gnt_any && !w_gnt_port;
      o_m1_gnt = w_gnt_any &&  w_gnt_port;

      o_mem_we   = 1'b0;
      o_mem_addr = '0;
      o_mem_data = '0;
      if (w_gnt_any) begin
         o_mem_we   = w_we[w_gnt_port];
         o_mem_addr = w_addr[w_gnt_port];
         o_mem_data = w_data[w_gnt_port];
      end
   end

   // ---------------------------------------------------------------------------
   // Read return path: the memory output is routed to the owner of the read
   // granted on the previous cycle and forced to zero everywhere else.
   // ---------------------------------------------------------------------------
   assign o_m0_rvalid = r_rpend && !r_rsel;
   assign o_m1_rvalid = r_rpend &&  r_rsel;
   assign o_m0_rdata  = o_m0_rvalid ? i_mem_in : '0;
   assign o_m1_rdata  = o_m1_rvalid ? i_mem_in : '0;

endmodule
